// File: rtl/gerenciador_zonas.sv
// Multi-zone lamp scheduler: per-zone IDLE/PEND/ON FSMs, round-robin grants under a shared
// lamp budget, idle timeout. Define PREEMPT_EN to let waiting zones preempt long-lit idle zones.
module gerenciador_zonas #(
  parameter int unsigned N_ZONAS    = 4,
  parameter int unsigned MAX_ATIVAS = 2,
  parameter int unsigned TIMEOUT_T  = 30000,
  parameter int unsigned HOLD_T     = 5000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [N_ZONAS-1:0]              pres,
  output logic [N_ZONAS-1:0]              lamp,
  output logic [$clog2(MAX_ATIVAS+1)-1:0] ativas,
  output logic                            pend
);
  localparam int unsigned AW = $clog2(MAX_ATIVAS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_T + 1);
  localparam int unsigned PW = $clog2(N_ZONAS);

  typedef enum logic [1:0] {StIdle, StPend, StOn} zone_st_e;

  zone_st_e           st_q  [N_ZONAS];
  zone_st_e           st_d  [N_ZONAS];
  logic [TW-1:0]      tmr_q [N_ZONAS];
  logic [TW-1:0]      tmr_d [N_ZONAS];
  logic [PW-1:0]      rr_q, rr_d;
  logic [PW-1:0]      cand;
  logic [AW-1:0]      ativas_q, ativas_d;
  logic               pend_q, pend_d;
  logic [N_ZONAS-1:0] grant;
  logic [N_ZONAS-1:0] preempt;

  // Round-robin search from rr_q; the registered count gates grants so a slot freed this
  // edge is only handed out on the next one.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    cand  = '0;
    if (en && (ativas_q < AW'(MAX_ATIVAS))) begin
      for (int unsigned k = 0; k < N_ZONAS; k++) begin
        if (32'(rr_q) + k >= N_ZONAS) begin
          cand = PW'(32'(rr_q) + k - N_ZONAS);
        end else begin
          cand = PW'(32'(rr_q) + k);
        end
        if ((grant == '0) && (st_q[cand] == StPend)) begin
          grant[cand] = 1'b1;
          rr_d        = (cand == PW'(N_ZONAS - 1)) ? '0 : cand + 1'b1;
        end
      end
    end
  end

`ifdef PREEMPT_EN
  localparam int unsigned HW = (HOLD_T > 0) ? $clog2(HOLD_T + 1) : 1;

  logic [HW-1:0] lit_q [N_ZONAS];
  logic [HW-1:0] lit_d [N_ZONAS];
  logic          pre_found;
  logic          pre_any;
  logic [TW-1:0] pre_best_t;
  logic [PW-1:0] pre_idx;

  // Victim is the eligible zone idle the longest; strict '>' keeps the lowest index on ties.
  always_comb begin
    preempt    = '0;
    pre_found  = 1'b0;
    pre_any    = 1'b0;
    pre_best_t = '0;
    pre_idx    = '0;
    for (int unsigned i = 0; i < N_ZONAS; i++) begin
      if (st_q[i] == StPend) pre_any = 1'b1;
      if ((st_q[i] == StOn) && (lit_q[i] >= HW'(HOLD_T)) &&
          (!pre_found || (tmr_q[i] > pre_best_t))) begin
        pre_found  = 1'b1;
        pre_best_t = tmr_q[i];
        pre_idx    = PW'(i);
      end
    end
    if (pre_found && pre_any && (ativas_q == AW'(MAX_ATIVAS))) preempt[pre_idx] = 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < N_ZONAS; i++) begin
      lit_d[i] = '0;
      if ((st_q[i] == StOn) && (st_d[i] == StOn)) begin
        lit_d[i] = (lit_q[i] >= HW'(HOLD_T)) ? lit_q[i] : lit_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ZONAS; i++) begin
      if (!rst) lit_q[i] <= '0;
      else      lit_q[i] <= lit_d[i];
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_T;
  assign preempt     = '0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_ZONAS; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = '0;
      unique case (st_q[i])
        StIdle: if (pres[i]) st_d[i] = StPend;
        StPend: if (grant[i]) st_d[i] = StOn;
        StOn: begin
          if (!pres[i]) tmr_d[i] = tmr_q[i] + 1'b1;
          if (preempt[i] || (!pres[i] && (tmr_q[i] == TW'(TIMEOUT_T - 1)))) st_d[i] = StIdle;
        end
        default: st_d[i] = StIdle;
      endcase
      if (!en) st_d[i] = StIdle;
      if (st_d[i] != StOn) tmr_d[i] = '0;
    end
  end

  always_comb begin
    ativas_d = '0;
    pend_d   = 1'b0;
    for (int unsigned i = 0; i < N_ZONAS; i++) begin
      if (st_d[i] == StOn)   ativas_d = ativas_d + 1'b1;
      if (st_d[i] == StPend) pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ZONAS; i++) begin
        st_q[i]  <= StIdle;
        tmr_q[i] <= '0;
      end
      rr_q     <= '0;
      ativas_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_ZONAS; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      rr_q     <= rr_d;
      ativas_q <= ativas_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    lamp = '0;
    for (int unsigned i = 0; i < N_ZONAS; i++) lamp[i] = (st_q[i] == StOn);
  end

  assign ativas = ativas_q;
  assign pend   = pend_q;

endmodule

// File: tb/tb_gerenciador_zonas.sv
// Bench for gerenciador_zonas: timestamp-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized presence/enable/reset traffic.
module tb_gerenciador_zonas;
  localparam int N    = 4;
  localparam int MAXA = 2;
  localparam int TO   = 10;
  localparam int HOLD = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] pres;
  logic [N-1:0] lamp;
  logic [1:0]   ativas;
  logic         pend;

  int n_chk  = 0;
  int n_fail = 0;

  gerenciador_zonas #(
    .N_ZONAS   (N),
    .MAX_ATIVAS(MAXA),
    .TIMEOUT_T (TO),
    .HOLD_T    (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pres  (pres),
    .lamp  (lamp),
    .ativas(ativas),
    .pend  (pend)
  );

  always #5 clk = ~clk;

  // Model: zone status plus the edge numbers of the grant and of the last activity
  // (grant or presence seen). A lit zone dies exactly TO edges after its last activity.
  int           m_st [N];  // 0 idle, 1 waiting, 2 lit
  int           m_grant_t [N];
  int           m_last [N];
  int           m_rr = 0;
  int           ncyc = 0;
  bit           m_valid = 1'b0;
  logic [N-1:0] exp_lamp;
  int           exp_ativas;
  bit           exp_pend;

  task automatic model_step();
    int on_cnt, gi, pi;
    bit anyp;
    ncyc++;
    if (!rst) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_rr    = 0;
      m_valid = 1'b1;
    end else if (!en) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
    end else begin
      on_cnt = 0;
      anyp   = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 2) on_cnt++;
        if (m_st[i] == 1) anyp = 1'b1;
      end
      gi = -1;
      if (on_cnt < MAXA) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && m_st[(m_rr + k) % N] == 1) gi = (m_rr + k) % N;
        end
      end
      pi = -1;
`ifdef PREEMPT_EN
      if (on_cnt == MAXA && anyp) begin
        for (int i = 0; i < N; i++) begin
          if (m_st[i] == 2 && (ncyc - 1 - m_grant_t[i]) >= HOLD &&
              (pi < 0 || m_last[i] < m_last[pi])) pi = i;
        end
      end
`endif
      for (int i = 0; i < N; i++) begin
        case (m_st[i])
          0: if (pres[i]) m_st[i] = 1;
          1: if (i == gi) begin
            m_st[i]      = 2;
            m_grant_t[i] = ncyc;
            m_last[i]    = ncyc;
          end
          default: begin
            if (i == pi)                    m_st[i] = 0;
            else if (pres[i])               m_last[i] = ncyc;
            else if (ncyc - m_last[i] == TO) m_st[i] = 0;
          end
        endcase
      end
      if (gi >= 0) m_rr = (gi + 1) % N;
    end
    exp_lamp   = '0;
    exp_ativas = 0;
    exp_pend   = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_lamp[i] = (m_st[i] == 2);
      if (m_st[i] == 2) exp_ativas++;
      if (m_st[i] == 1) exp_pend = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, ncyc, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] l, input int a, input bit p);
    check({name, "_lamp"}, 32'(lamp), 32'(l));
    check({name, "_ativas"}, 32'(ativas), 32'(a));
    check({name, "_pend"}, 32'(pend), 32'(p));
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_valid) begin
      check("model_lamp", 32'(lamp), 32'(exp_lamp));
      check("model_ativas", 32'(ativas), 32'(exp_ativas));
      check("model_pend", 32'(pend), 32'(exp_pend));
    end
  end

  initial begin
    int dens;
    rst  = 1'b0;
    en   = 1'b1;
    pres = '1;
    // Reset, then round-robin fill of the two slots
    repeat (2) @(negedge clk);
    expect_out("t1_reset", 4'b0000, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk); expect_out("t1_req", 4'b0000, 0, 1'b1);
    @(negedge clk); expect_out("t1_z0", 4'b0001, 1, 1'b1);
    @(negedge clk); expect_out("t1_z1", 4'b0011, 2, 1'b1);
    // Timeout release and pointer fairness
    pres = 4'b1110;
    repeat (9) @(negedge clk);
    expect_out("t3_z0_hold", 4'b0011, 2, 1'b1);
    @(negedge clk); expect_out("t3_z0_off", 4'b0010, 1, 1'b1);
    @(negedge clk); expect_out("t3_z2_on", 4'b0110, 2, 1'b1);
    pres = 4'b1100;
    repeat (9) @(negedge clk);
    expect_out("t3_z1_hold", 4'b0110, 2, 1'b1);
    @(negedge clk); expect_out("t3_z1_off", 4'b0100, 1, 1'b1);
    @(negedge clk); expect_out("t3_z3_on", 4'b1100, 2, 1'b0);
    // Global disable and re-arm
    pres = 4'b1101;
    @(negedge clk); expect_out("t5_pending", 4'b1100, 2, 1'b1);
    en = 1'b0;
    @(negedge clk); expect_out("t5_en_off", 4'b0000, 0, 1'b0);
    en = 1'b1;
    @(negedge clk); expect_out("t5_rearm", 4'b0000, 0, 1'b1);
    @(negedge clk); expect_out("t5_z0", 4'b0001, 1, 1'b1);
    @(negedge clk); expect_out("t5_z2", 4'b0101, 2, 1'b1);
    pres = '0;
    en   = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    // Sustained presence
    pres = 4'b0010;
    repeat (2) @(negedge clk);
    expect_out("t4_on", 4'b0010, 1, 1'b0);
    repeat (48) @(negedge clk);
    expect_out("t4_held", 4'b0010, 1, 1'b0);
    pres = '0;
    repeat (9) @(negedge clk);
    expect_out("t4_tail", 4'b0010, 1, 1'b0);
    @(negedge clk); expect_out("t4_off", 4'b0000, 0, 1'b0);
    // Single-cycle request: lit for exactly TO cycles
    pres = 4'b0001;
    @(negedge clk);
    pres = '0;
    expect_out("t2_req", 4'b0000, 0, 1'b1);
    repeat (10) @(negedge clk);
    expect_out("t2_lit", 4'b0001, 1, 1'b0);
    @(negedge clk); expect_out("t2_off", 4'b0000, 0, 1'b0);
    // Full budget, late requester
    rst = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    pres = 4'b0011;
    @(negedge clk);
    pres = '0;
    repeat (7) @(negedge clk);
    pres = 4'b1000;
    @(negedge clk);
    pres = '0;
    @(negedge clk);
`ifdef PREEMPT_EN
    expect_out("t6_preempt", 4'b0010, 1, 1'b1);
    @(negedge clk); expect_out("t6_z3_on", 4'b1010, 2, 1'b0);
`else
    expect_out("t6_wait", 4'b0011, 2, 1'b1);
    @(negedge clk); expect_out("t6_wait2", 4'b0011, 2, 1'b1);
    @(negedge clk); expect_out("t6_z0_timeout", 4'b0010, 1, 1'b1);
    @(negedge clk); expect_out("t6_z3_on", 4'b1000, 1, 1'b0);
`endif
    // Random traffic
    dens = 4;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 100 == 0) dens = $urandom_range(1, 20);
      rst = ($urandom_range(0, 199) != 0);
      en  = ($urandom_range(0, 59) != 0);
      for (int b = 0; b < N; b++) pres[b] = ($urandom_range(0, dens) == 0);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
